// File: rtl/cluster_pkg.sv
// Shared types and width helpers for the cluster scanner.
package cluster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  function automatic int ch_width(input int channel_num);
    return (channel_num > 1) ? $clog2(channel_num) : 1;
  endfunction

  function automatic int sum_width(input int data_w, input int channel_num);
    return data_w + ch_width(channel_num);
  endfunction

endpackage

// File: rtl/cluster_scan_run_tracker.sv
// Tracks the currently open over-threshold run and reports it on the beat that closes it.
module run_tracker #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 9,
  parameter int SUM_W  = 25,
  parameter int LEN_W  = 10
) (
  input  logic                     clk_clk,
  input  logic                     rst_reset,
  input  logic                     beat,
  input  logic                     restart,
  input  logic                     over,
  input  logic                     final_beat,
  input  logic [CH_W-1:0]          addr,
  input  logic signed [DATA_W-1:0] data,
  output logic                     close_valid,
  output logic [CH_W-1:0]          close_left,
  output logic [CH_W-1:0]          close_right,
  output logic [LEN_W-1:0]         close_len,
  output logic signed [SUM_W-1:0]  close_sum
);

  logic                    active;
  logic [CH_W-1:0]         start;
  logic [LEN_W-1:0]        len;
  logic signed [SUM_W-1:0] sum;

  logic                    open_run;
  logic [CH_W-1:0]         ext_start;
  logic [LEN_W-1:0]        ext_len;
  logic signed [SUM_W-1:0] ext_sum;
  logic signed [SUM_W-1:0] data_ext;

  assign data_ext = {{(SUM_W-DATA_W){data[DATA_W-1]}}, data};

  // A restart beat sees no open run: it is channel 0 of a fresh frame.
  always_comb begin
    open_run    = active && !restart;
    ext_start   = open_run ? start : addr;
    ext_len     = open_run ? len + 1'b1 : LEN_W'(1);
    ext_sum     = (open_run ? sum : '0) + data_ext;
    close_valid = beat && (over ? final_beat : open_run);
    if (over) begin
      close_left  = ext_start;
      close_right = addr;
      close_len   = ext_len;
      close_sum   = ext_sum;
    end else begin
      close_left  = start;
      close_right = addr - 1'b1;
      close_len   = len;
      close_sum   = sum;
    end
  end

  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      active <= 1'b0;
      start  <= '0;
      len    <= '0;
      sum    <= '0;
    end else if (beat) begin
      if (over && !final_beat) begin
        active <= 1'b1;
        start  <= ext_start;
        len    <= ext_len;
        sum    <= ext_sum;
      end else begin
        active <= 1'b0;
        start  <= '0;
        len    <= '0;
        sum    <= '0;
      end
    end
  end

endmodule

// File: rtl/cluster_scan.sv
// Frame-based cluster finder: counts qualifying over-threshold runs and reports the widest one.
module cluster_scan
  import cluster_pkg::*;
#(
  parameter int  CHANNEL_NUM = 320,
  parameter int  DATA_W      = 16,
  parameter int  CNT_W       = 6,
  localparam int CH_W        = ch_width(CHANNEL_NUM),
  localparam int SUM_W       = sum_width(DATA_W, CHANNEL_NUM)
) (
  input  logic              clk_clk,
  input  logic              rst_reset,
  input  logic [DATA_W-1:0] cfg_threshold,
  input  logic [CH_W-1:0]   cfg_min_size,
  input  logic [DATA_W-1:0] data_in_data,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic              data_in_startofpacket,
  input  logic              data_in_endofpacket,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_found,
  output logic [CNT_W-1:0]  res_count,
  output logic [CH_W-1:0]   res_left,
  output logic [CH_W-1:0]   res_right,
  output logic [SUM_W-1:0]  res_sum,
  output logic              res_error
);

  localparam int              LEN_W     = CH_W + 1;
  localparam logic [CH_W-1:0] LAST_ADDR = CH_W'(CHANNEL_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Handshake: a beat moves when data_in_valid && data_in_ready; a result
  // is held on res_* from res_valid rising until res_valid && res_ready.
  state_t state, state_nxt;

  logic signed [DATA_W-1:0] thr_q, thr_eff;
  logic [CH_W-1:0]          min_q, min_raw;
  logic [LEN_W-1:0]         min_eff;
  logic [CH_W-1:0]          addr, beat_addr;
  logic [CNT_W-1:0]         count, count_eff;
  logic [CH_W-1:0]          best_left, best_right;
  logic [LEN_W-1:0]         best_len, best_len_eff;
  logic signed [SUM_W-1:0]  best_sum;
  logic                     err;

  logic accept, start, beat, last_addr, final_beat, over, qualify;

  logic                    close_valid;
  logic [CH_W-1:0]         close_left, close_right;
  logic [LEN_W-1:0]        close_len;
  logic signed [SUM_W-1:0] close_sum;

  assign data_in_ready = (state != ST_REPORT);
  assign res_valid     = (state == ST_REPORT);

  // An SOP beat starts a frame from IDLE or aborts and restarts one in SCAN.
  always_comb begin
    accept       = data_in_valid && data_in_ready;
    start        = accept && data_in_startofpacket;
    beat         = accept && (start || state == ST_SCAN);
    beat_addr    = start ? '0 : addr;
    last_addr    = (beat_addr == LAST_ADDR);
    final_beat   = beat && (data_in_endofpacket || last_addr);
    thr_eff      = start ? $signed(cfg_threshold) : thr_q;
    min_raw      = start ? cfg_min_size : min_q;
    min_eff      = (min_raw == '0) ? LEN_W'(1) : {1'b0, min_raw};
    over         = $signed(data_in_data) > thr_eff;
    count_eff    = start ? '0 : count;
    best_len_eff = start ? '0 : best_len;
    qualify      = close_valid && (close_len >= min_eff);
  end

  run_tracker #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .SUM_W  (SUM_W),
    .LEN_W  (LEN_W)
  ) u_run_tracker (
    .clk_clk     (clk_clk),
    .rst_reset   (rst_reset),
    .beat        (beat),
    .restart     (start),
    .over        (over),
    .final_beat  (final_beat),
    .addr        (beat_addr),
    .data        ($signed(data_in_data)),
    .close_valid (close_valid),
    .close_left  (close_left),
    .close_right (close_right),
    .close_len   (close_len),
    .close_sum   (close_sum)
  );

  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_SCAN: begin
        if (beat) state_nxt = final_beat ? ST_REPORT : ST_SCAN;
      end
      ST_REPORT: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Later assignments override the SOP clear so a one-beat frame is still scored.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      thr_q      <= '0;
      min_q      <= '0;
      addr       <= '0;
      count      <= '0;
      best_left  <= '0;
      best_right <= '0;
      best_len   <= '0;
      best_sum   <= '0;
      err        <= 1'b0;
    end else begin
      if (start) begin
        thr_q      <= $signed(cfg_threshold);
        min_q      <= cfg_min_size;
        count      <= '0;
        best_left  <= '0;
        best_right <= '0;
        best_len   <= '0;
        best_sum   <= '0;
        err        <= 1'b0;
      end
      if (beat) addr <= beat_addr + 1'b1;
      if (qualify && count_eff != CNT_MAX) count <= count_eff + 1'b1;
      if (qualify && close_len > best_len_eff) begin
        best_left  <= close_left;
        best_right <= close_right;
        best_len   <= close_len;
        best_sum   <= close_sum;
      end
      if (final_beat) err <= !(data_in_endofpacket && last_addr);
    end
  end

  assign res_count = count;
  assign res_found = (count != '0);
  assign res_left  = best_left;
  assign res_right = best_right;
  assign res_sum   = best_sum;
  assign res_error = err;

endmodule

// File: tb/tb_cluster_scan.sv
// Randomized frame-level bench for cluster_scan against a run-list reference model.
module tb_cluster_scan;

  localparam int CH  = 320;
  localparam int DW  = 16;
  localparam int CW  = 6;
  localparam int CHW = 9;
  localparam int SW  = 25;

  typedef struct packed {
    logic           found;
    logic [CW-1:0]  count;
    logic [CHW-1:0] left;
    logic [CHW-1:0] right;
    logic [SW-1:0]  sum;
    logic           err;
  } res_t;

  logic           clk_clk = 1'b0;
  logic           rst_reset = 1'b1;
  logic [DW-1:0]  cfg_threshold = '0;
  logic [CHW-1:0] cfg_min_size = '0;
  logic [DW-1:0]  data_in_data = '0;
  logic           data_in_valid = 1'b0;
  logic           data_in_ready;
  logic           data_in_startofpacket = 1'b0;
  logic           data_in_endofpacket = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic           res_found;
  logic [CW-1:0]  res_count;
  logic [CHW-1:0] res_left;
  logic [CHW-1:0] res_right;
  logic [SW-1:0]  res_sum;
  logic           res_error;

  int   checks = 0;
  int   errors = 0;
  int   samples[$];
  res_t got;
  bit   got_ok, hold_ok, release_ok;

  // ---------------- clock / reset ----------------
  always #5 clk_clk = ~clk_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  cluster_scan #(
    .CHANNEL_NUM (CH),
    .DATA_W      (DW),
    .CNT_W       (CW)
  ) dut (
    .clk_clk               (clk_clk),
    .rst_reset             (rst_reset),
    .cfg_threshold         (cfg_threshold),
    .cfg_min_size          (cfg_min_size),
    .data_in_data          (data_in_data),
    .data_in_valid         (data_in_valid),
    .data_in_ready         (data_in_ready),
    .data_in_startofpacket (data_in_startofpacket),
    .data_in_endofpacket   (data_in_endofpacket),
    .res_valid             (res_valid),
    .res_ready             (res_ready),
    .res_found             (res_found),
    .res_count             (res_count),
    .res_left              (res_left),
    .res_right             (res_right),
    .res_sum               (res_sum),
    .res_error             (res_error)
  );

  // ---------------- reference model ----------------
  // Scans the frame as a list of runs; beats past the last channel are ignored.
  function automatic res_t model(input int thr, input int min_size, input bit has_eop);
    res_t   r = '0;
    int     last_i, i, j, len, mn, best_len, cnt;
    longint sum;
    last_i = samples.size() - 1;
    if (last_i > CH - 1) last_i = CH - 1;
    mn = (min_size == 0) ? 1 : min_size;
    best_len = 0;
    cnt = 0;
    i = 0;
    while (i <= last_i) begin
      if (samples[i] > thr) begin
        j = i;
        sum = samples[i];
        while (j < last_i && samples[j+1] > thr) begin
          j++;
          sum += samples[j];
        end
        len = j - i + 1;
        if (len >= mn) begin
          if (cnt < (1 << CW) - 1) cnt++;
          if (len > best_len) begin
            best_len = len;
            r.left   = CHW'(i);
            r.right  = CHW'(j);
            r.sum    = SW'(sum);
          end
        end
        i = j + 1;
      end else begin
        i++;
      end
    end
    r.count = CW'(cnt);
    r.found = (cnt != 0);
    r.err   = !(has_eop && samples.size() == CH);
    return r;
  endfunction

  // ---------------- stimulus builders ----------------
  task automatic fill(input int n, input int v);
    samples.delete();
    repeat (n) samples.push_back(v);
  endtask

  task automatic gen_random(input int n, input int thr);
    bit ov = 1'b0;
    samples.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) ov = !ov;
      if (ov) samples.push_back(thr + int'($urandom_range(1, 400)));
      else    samples.push_back(thr - int'($urandom_range(0, 400)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_frame(input bit has_eop, input int thr, input int min_size);
    int n;
    cfg_threshold = DW'(thr);
    cfg_min_size  = CHW'(min_size);
    for (int i = 0; i < samples.size(); i++) begin
      @(negedge clk_clk);
      if (i == 1) begin
        cfg_threshold = DW'($urandom);
        cfg_min_size  = CHW'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 4) == 0) begin
        data_in_valid = 1'b0;
        @(negedge clk_clk);
      end
      data_in_valid         = 1'b1;
      data_in_data          = DW'(samples[i]);
      data_in_startofpacket = (i == 0);
      data_in_endofpacket   = has_eop && (i == samples.size() - 1);
      n = 0;
      while (!data_in_ready && n < 200) begin
        @(negedge clk_clk);
        n++;
      end
      if (!data_in_ready) begin
        checks++;
        errors++;
        $display("FAIL beat_stall: beat %0d not accepted after %0d cycles", i, n);
      end
      @(posedge clk_clk);
    end
    @(negedge clk_clk);
    data_in_valid         = 1'b0;
    data_in_startofpacket = 1'b0;
    data_in_endofpacket   = 1'b0;
  endtask

  task automatic collect(input int hold);
    int n = 0;
    got_ok = 1'b0;
    hold_ok = 1'b1;
    release_ok = 1'b1;
    got = '0;
    do begin
      @(negedge clk_clk);
      n++;
    end while (!res_valid && n < 5000);
    if (!res_valid) return;
    got_ok = 1'b1;
    got = {res_found, res_count, res_left, res_right, res_sum, res_error};
    repeat (hold) begin
      @(negedge clk_clk);
      if (!res_valid || data_in_ready ||
          res_t'({res_found, res_count, res_left, res_right, res_sum, res_error}) !== got)
        hold_ok = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk_clk);
    res_ready = 1'b0;
    if (res_valid) release_ok = 1'b0;
  endtask

  task automatic run_frame(input int thr, input int min_size, input bit has_eop, input int hold);
    fork
      drive_frame(has_eop, thr, min_size);
      collect(hold);
    join
  endtask

  task automatic apply_reset();
    @(negedge clk_clk);
    rst_reset = 1'b1;
    data_in_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk_clk);
    rst_reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk_clk);
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b expected 1", data_in_ready);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b expected 0", res_valid);
    end
    checks++;
    if ({res_found, res_count, res_left, res_right, res_sum, res_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: found=%0b count=%0d left=%0d right=%0d sum=%0d err=%0b expected all 0",
               res_found, res_count, res_left, res_right, res_sum, res_error);
    end
  endtask

  task automatic test_single_run();
    res_t exp;
    fill(CH, 0);
    for (int i = 10; i <= 17; i++) samples[i] = 100;
    exp = model(54, 4, 1);
    run_frame(54, 4, 1, 2);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL single_run: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_tie();
    res_t exp;
    fill(CH, 0);
    for (int i = 5; i <= 7; i++) samples[i] = 100;
    for (int i = 50; i <= 54; i++) samples[i] = 70;
    for (int i = 200; i <= 204; i++) samples[i] = 900;
    exp = model(54, 4, 1);
    run_frame(54, 4, 1, 1);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL earliest_tie: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_eop_close();
    res_t exp;
    fill(CH, 0);
    for (int i = 316; i <= 319; i++) samples[i] = 200 + i;
    exp = model(54, 4, 1);
    run_frame(54, 4, 1, 0);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL eop_close: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_short_eop();
    res_t exp;
    fill(201, 0);
    for (int i = 30; i <= 40; i++) samples[i] = 60;
    exp = model(54, 2, 1);
    run_frame(54, 2, 1, 0);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL short_eop: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_no_eop();
    res_t exp;
    fill(330, 0);
    for (int i = 100; i <= 110; i++) samples[i] = 300;
    for (int i = 315; i <= 325; i++) samples[i] = 400;
    exp = model(54, 3, 1);
    run_frame(54, 3, 1, 5);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL no_eop: valid=%0b got %p expected %p", got_ok, got, exp);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL no_eop_hold: outputs or data_in_ready changed while result pending");
    end
    gen_random(CH, 10);
    exp = model(10, 2, 1);
    run_frame(10, 2, 1, 0);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL no_eop_next: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_backpressure();
    res_t exp;
    gen_random(CH, -50);
    exp = model(-50, 3, 1);
    run_frame(-50, 3, 1, 20);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL backpressure: valid=%0b got %p expected %p", got_ok, got, exp);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL backpressure_hold: outputs changed or data_in_ready high while res_ready low");
    end
    checks++;
    if (!release_ok) begin
      errors++;
      $display("FAIL backpressure_release: res_valid still 1 after handshake");
    end
    gen_random(CH, 300);
    exp = model(300, 1, 1);
    run_frame(300, 1, 1, 0);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL backpressure_next: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_abort();
    res_t exp;
    fill(100, 0);
    for (int i = 20; i <= 60; i++) samples[i] = 500;
    drive_frame(1'b0, 54, 2);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result: res_valid got %0b expected 0", res_valid);
    end
    fill(CH, 0);
    for (int i = 5; i <= 7; i++) samples[i] = 80;
    for (int i = 100; i <= 103; i++) samples[i] = 90;
    exp = model(54, 2, 1);
    run_frame(54, 2, 1, 1);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL abort_restart: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_reset_mid();
    res_t exp;
    fill(60, 0);
    for (int i = 10; i <= 30; i++) samples[i] = 700;
    drive_frame(1'b0, 54, 2);
    apply_reset();
    @(negedge clk_clk);
    checks++;
    if (res_valid !== 1'b0 || res_count !== '0 || data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_scan: valid=%0b count=%0d ready=%0b expected 0/0/1",
               res_valid, res_count, data_in_ready);
    end
    fill(CH, 0);
    for (int i = 40; i <= 45; i++) samples[i] = 100;
    drive_frame(1'b1, 54, 2);
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_latency: res_valid got %0b expected 1 one cycle after EOP", res_valid);
    end
    apply_reset();
    @(negedge clk_clk);
    checks++;
    if (res_valid !== 1'b0 || res_found !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_report: valid=%0b found=%0b expected 0/0", res_valid, res_found);
    end
    gen_random(CH, 0);
    exp = model(0, 4, 1);
    run_frame(0, 4, 1, 2);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL reset_next: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_negative();
    res_t exp;
    samples.delete();
    repeat (CH) samples.push_back(-int'($urandom_range(1, 20)));
    exp = model(-5, 2, 1);
    run_frame(-5, 2, 1, 1);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL signed_compare: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_saturate();
    res_t exp;
    samples.delete();
    for (int i = 0; i < CH; i++) samples.push_back((i % 2 == 0) ? 100 : 0);
    exp = model(54, 0, 1);
    run_frame(54, 0, 1, 1);
    checks++;
    if (!got_ok || got !== exp) begin
      errors++;
      $display("FAIL count_saturate: valid=%0b got %p expected %p", got_ok, got, exp);
    end
  endtask

  task automatic test_random();
    res_t exp;
    int   thr, mn, len;
    repeat (8) begin
      thr = int'($urandom_range(0, 2000)) - 1000;
      mn  = int'($urandom_range(0, 6));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, CH - 1)) : CH;
      gen_random(len, thr);
      exp = model(thr, mn, 1);
      run_frame(thr, mn, 1, int'($urandom_range(0, 3)));
      checks++;
      if (!got_ok || got !== exp) begin
        errors++;
        $display("FAIL random_frame: thr=%0d min=%0d len=%0d valid=%0b got %p expected %p",
                 thr, mn, len, got_ok, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t exp;
    int   thr;
    repeat (4) begin
      thr = int'($urandom_range(0, 400)) - 200;
      gen_random(CH, thr);
      exp = model(thr, 2, 1);
      run_frame(thr, 2, 1, 0);
      checks++;
      if (!got_ok || got !== exp) begin
        errors++;
        $display("FAIL back_to_back: thr=%0d valid=%0b got %p expected %p", thr, got_ok, got, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_run();
    test_tie();
    test_eop_close();
    test_short_eop();
    test_no_eop();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_negative();
    test_saturate();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_scan.md
CLUSTER_SCAN -- requirements
Module: cluster_scan

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 320, meaning channels per frame.
REQ-002 SHALL have parameter DATA_W, default 16, meaning signed sample width.
REQ-003 SHALL have parameter CNT_W, default 6, meaning cluster-count width.
REQ-004 SHALL derive localparams CH_W = clog2(CHANNEL_NUM) and SUM_W = DATA_W+CH_W.
REQ-005 SHALL have ports:
 clk_clk  in  1  clock.
 rst_reset  in  1  asynchronous, active-high reset.
 cfg_threshold  in  DATA_W  signed threshold.
 cfg_min_size  in  CH_W  minimum run length.
 data_in_data  in  DATA_W  signed sample.
 data_in_valid  in  1  beat valid.
 data_in_ready  out  1  sink ready.
 data_in_startofpacket  in  1  first channel.
 data_in_endofpacket  in  1  last channel.
 res_valid  out  1  result valid.
 res_ready  in  1  result accepted.
 res_found  out  1  at least one cluster.
 res_count  out  CNT_W  qualifying clusters.
 res_left  out  CH_W  widest cluster first channel.
 res_right  out  CH_W  widest cluster last channel.
 res_sum  out  SUM_W  signed sample sum of widest cluster.
 res_error  out  1  frame length error.

Function
REQ-006 SHALL treat a beat as accepted when data_in_valid and data_in_ready are both high.
REQ-007 SHALL have states IDLE, SCAN and REPORT; data_in_ready SHALL be 1 in IDLE and SCAN and 0 in REPORT.
REQ-008 In IDLE, non-SOP beats SHALL be dropped; an SOP beat SHALL latch cfg_threshold and cfg_min_size, clear all accumulators, process the beat as channel 0, and move to SCAN.
REQ-009 The channel address SHALL be an internal counter: 0 on the SOP beat, incremented per accepted beat.
REQ-010 A sample SHALL be over threshold when it is strictly greater than the latched threshold, using a signed compare.
REQ-011 A run SHALL be a maximal sequence of consecutive over-threshold channels; it qualifies when its length is >= the latched min_size, and min_size 0 SHALL be treated as 1.
REQ-012 Each qualifying run SHALL increment the count, which saturates at 2^CNT_W-1.
REQ-013 A qualifying run longer than the stored widest run SHALL replace left, right and sum; on equal length the earlier run SHALL be kept.
REQ-014 A run SHALL close on the first below-threshold beat (right = address-1) or on the EOP beat if that beat is over threshold (right = address).
REQ-015 The run sum SHALL be the sign-extended SUM_W accumulation of raw samples, with no overflow handling required.
REQ-016 On an EOP beat the block SHALL enter REPORT; res_error SHALL be 1 if the EOP address != CHANNEL_NUM-1.
REQ-017 If the address reaches CHANNEL_NUM-1 without EOP, res_error SHALL be set, the block SHALL enter REPORT, and later beats up to and including EOP SHALL be dropped in IDLE.
REQ-018 An SOP beat arriving in SCAN SHALL abort the current frame and restart it per REQ-008, with no result issued.
REQ-019 res_valid SHALL rise on the cycle after the closing beat, and all res_* SHALL be held stable until res_valid and res_ready are both high; the block SHALL then return to IDLE.
REQ-020 res_found SHALL equal (res_count != 0); when res_found is 0, res_left, res_right and res_sum SHALL be 0.

Reset
REQ-021 Reset SHALL force IDLE, with res_valid=0, res_found=0, res_error=0, res_count, res_left, res_right and res_sum at 0, data_in_ready=1 on the first cycle after release, and all accumulators cleared.
REQ-022 Reset asserted mid-frame or in REPORT SHALL discard the frame with no result issued.

Structure
REQ-023 The state encoding and the CH_W and SUM_W derivation functions SHALL live in shared package cluster_pkg.
REQ-024 A sub-module run_tracker (run length, start and sum for the open run) is natural, and cluster_scan SHALL own address, best-run register, count and FSM.

Verification
REQ-025 Threshold 54, min 4, channels 10-17 = 100, others 0 → count 1, left 10, right 17, sum 800, error 0.
REQ-026 Runs at 5-7 (len 3) and 50-54 and 200-204 (len 5) → count 2, left 50, right 54 (earliest tie).
REQ-027 Channels 316-319 over threshold, min 4 → count 1, left 316, right 319 (closed at EOP).
REQ-028 EOP at address 200 → res_error 1; 330 beats with no EOP → error 1 at address 319, with the remainder dropped.
REQ-029 res_ready held low 20 cycles → outputs stable, data_in_ready 0; then a handshake returns to IDLE and the next frame is accepted.
REQ-030 SOP mid-frame at address 100, and reset asserted mid-frame → no result and a correct next frame; all-negative samples with threshold -5 → signed compare verified.
